// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding, data width, parity helper.
// No logic; imported by uart_rx and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } uart_rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous level, both flops reset to 1.
// Latency 2 cycles; no flow control.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with byte checksum; optional even parity via UART_RX_PARITY_EN.
// Pulse outputs one cycle after the mid-stop sample; no backpressure (bytes are never held off).
module uart_rx
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_serial,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic [31:0] o_sum,
  output logic        o_frame_err,
  output logic        o_parity_err,
  output logic        o_idle
);

  localparam int CW = $clog2(cycles_per_bit + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(cycles_per_bit / 2);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(cycles_per_bit);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic s;

  uart_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_serial),
    .o_sync  (s)
  );

  uart_rx_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic [31:0]    sum_q, sum_d;
  logic           ferr_q, ferr_d;
  logic           idle_q, idle_d;
`ifdef UART_RX_PARITY_EN
  logic           par_err_q, par_err_d;
  logic           perr_q, perr_d;
`endif

  logic expire;
  assign expire = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!s) begin
          cnt_d   = HALF_LOAD;
          state_d = S_START;
        end
      end

      S_START: begin
        if (expire) begin
          if (s) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = BIT_LOAD;
            bit_d   = 3'd0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DATA: begin
        if (expire) begin
          shift_d = {s, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (expire) begin
          par_err_d = (s != even_parity(shift_q));
          cnt_d     = BIT_LOAD;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif

      S_STOP: begin
        if (expire) begin
          // Leaving mid stop bit leaves half a bit to catch a back-to-back start.
          if (!s) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            sum_d   = sum_q + {{(32 - UART_DATA_BITS){1'b0}}, shift_q};
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_BREAK: begin
        if (s) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    idle_d = (state_d == S_IDLE) && s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      ferr_q  <= 1'b0;
      idle_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      ferr_q  <= ferr_d;
      idle_q  <= idle_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sum       = sum_q;
  assign o_frame_err = ferr_q;
  assign o_idle      = idle_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with the existing transmitter in `uart_top`. It recovers 8N1 frames, with an optional parity bit, from one serial line and presents each byte as a one-cycle valid pulse. It keeps a running 32-bit byte checksum and flags framing and parity errors. It sits at the far end of the serial link so that benches and SoC tops can close the loop on `ser_tx`.

## Interface
- `cycles_per_bit`, default 3: clock cycles per serial bit. Minimum legal value is 3.
- `clk`  input  1  sole clock. All state updates on posedge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `i_serial`  input  1  serial line. Idles high. Asynchronous to `clk`.
- `o_data`  output  8  last good byte. Holds until the next good byte.
- `o_valid`  output  1  one-cycle pulse when `o_data` is updated.
- `o_sum`  output  32  running sum of all good bytes, modulo 2^32.
- `o_frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `o_parity_err`  output  1  one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.
- `o_idle`  output  1  high while in IDLE with the synchronized line high.

## Operation
- `i_serial` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized bit `s`.
- State machine: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: when `s`==0, load the bit counter with `h = cycles_per_bit/2` (integer division) and go to START.
- START: at counter expiry (mid start bit), if `s`==1 the start was a glitch and the block returns to IDLE with no output. Otherwise it reloads the counter with `cycles_per_bit` and goes to DATA.
- DATA: at each expiry, shift `s` into the shift register, LSB first. After bit 7 it goes to PARITY, or to STOP if parity is compiled out.
- PARITY: at expiry, compare `s` against the even parity of the 8 data bits, latch the mismatch, and go to STOP.
- STOP, at expiry (mid stop bit):
  - `s`==1 and no parity mismatch: `o_data`<=shift register, `o_valid`<=1, `o_sum`<=`o_sum`+{24'b0,byte}, then go to IDLE.
  - `s`==1 with a parity mismatch: `o_parity_err`<=1. Data and sum are untouched. Go to IDLE.
  - `s`==0: `o_frame_err`<=1. Data and sum are untouched. Go to BREAK. If parity also mismatched, only the framing error is reported.
- BREAK: wait for `s`==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- The return to IDLE happens mid stop bit, so back-to-back frames with a one-bit stop are received without loss.
- The counter is `$clog2(cycles_per_bit+1)` bits, counts down, and expires when it reaches 1.

## Timing
- Reset values: all outputs 0 except `o_idle`. `o_idle` becomes 1 at the first edge after reset release. State is IDLE, counter 0, shift register 0.
- Let D be the first edge at which IDLE sees `s`==0. `s` lags `i_serial` by 2 cycles.
- Start check happens at D+h.
- Data bit k (0..7) is sampled at D+h+(k+1)·cycles_per_bit.
- Parity is sampled at D+h+9·cycles_per_bit.
- Stop is sampled at D+h+(9 or 10)·cycles_per_bit.
- `o_valid`, `o_frame_err` and `o_parity_err` are registered. Each is high for exactly the one cycle after the stop-sample edge.
- `o_sum` and `o_data` update on the same edge that raises `o_valid`.
- If `rst_n` is asserted mid-frame, the partial frame is discarded. `o_sum` clears to 0. The first full frame after release is received correctly.
- `o_sum` wraps silently past 0xFFFFFFFF.

## Configuration
- `UART_RX_PARITY_EN` defined: each frame carries 1 even-parity bit between data and stop. The PARITY state and `o_parity_err` are live.
- `UART_RX_PARITY_EN` undefined: frames are 8N1. There is no PARITY state. `o_parity_err` is constant 0. Stop timing uses the 9·cycles_per_bit offset.
- The transmitter must be built with the matching setting.

## Structure
- `uart_pkg`: state enum `uart_rx_state_e`, `UART_DATA_BITS`=8, and the even-parity function shared with the transmitter.
- Sub-module `uart_sync`: 2-flop synchronizer with reset value 1. It is reused for other asynchronous inputs.
- All other logic lives in `uart_rx`.

## Test plan
All scenarios use `cycles_per_bit`=3 unless stated.
- Loopback from `uart_top` `ser_tx` -> the full message is received in order and `o_sum`==0x0000b764 when the transmitter reports `o_idle`.
- Single frame 0x55 -> exactly one `o_valid` pulse, `o_data`==0x55, `o_sum`==0x55, with `o_valid` at D+h+27+1.
- Back-to-back "Hello" with no idle gap -> 5 valid pulses and `o_sum`==0x1F4.
- 1-cycle low glitch on the idle line -> no valid and no error pulse, and `o_idle` returns high.
- Frame 0xA3 with stop bit held low for 20 bit times -> one `o_frame_err`, `o_sum` unchanged, then a following 0x01 frame gives `o_data`==0x01.
- Reset pulse mid-DATA of frame 0xFF, then frame 0x12 -> outputs 0 during reset, then `o_data`==0x12 and `o_sum`==0x12.
- With the macro defined: frame 0x07 with a wrong parity bit -> `o_parity_err` pulse and no `o_valid`.
